// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: key event and raw byte bundle produced by ps2_key_decoder.
//   key_strobe   - toggles once per decoded key event
//   key_pressed  - 1 = make, 0 = break
//   key_extended - event was prefixed by E0
//   key_code     - scan code byte of the event
//   byte_valid   - one-cycle pulse per good frame (prefix and response bytes too)
//   byte_data    - raw byte of the last good frame
//   frame_error  - one-cycle pulse on framing, parity or timeout error
// Modports: master drives the bundle (decoder), slave consumes it (keyboard matrix).
interface ps2_key_decoder_if;
    logic       key_strobe;
    logic       key_pressed;
    logic       key_extended;
    logic [7:0] key_code;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_error;

    modport master (
        output key_strobe,
        output key_pressed,
        output key_extended,
        output key_code,
        output byte_valid,
        output byte_data,
        output frame_error
    );

    modport slave (
        input key_strobe,
        input key_pressed,
        input key_extended,
        input key_code,
        input byte_valid,
        input byte_data,
        input frame_error
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver and scan-code-set-2 event decoder.
// Synchronizes and filters the raw PS/2 lines, deserializes 11-bit device-to-host
// frames, strips E0/F0/E1 prefixes, drops keyboard response bytes and emits one
// toggling key_strobe per completed make or break code.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   ps2_clk  - raw PS/2 clock (asynchronous)
//   ps2_data - raw PS/2 data (asynchronous)
//   key_if   - event/byte outputs (ps2_key_decoder_if.master)
// Parameters:
//   FILTER_LEN - consecutive synchronized samples needed to change the filtered clock
//   TIMEOUT    - clk cycles without a sample edge mid-frame before the frame aborts
// Build option:
//   PS2_PARITY_CHECK_EN - when defined, a parity mismatch is a frame error;
//                         otherwise the parity bit is sampled but ignored.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 60000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_key_decoder_if.master key_if
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // ---------------- input conditioning ----------------
    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_filt_q, clk_filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             clk_s, data_s, sample_edge;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_s == clk_filt_q) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
            clk_filt_d = clk_s;
            filt_cnt_d = '0;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    // The cycle in which the filtered level commits to 1->0 is the sample edge.
    assign sample_edge = clk_filt_q && !clk_s && (filt_cnt_q == FiltW'(FILTER_LEN - 1));

    // ---------------- frame FSM ----------------
    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           good_byte, frame_err, parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        good_byte = 1'b0;
        frame_err = 1'b0;

        if (state_q == StIdle || sample_edge) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                // A sample edge with data high is line noise; ignore silently.
                if (sample_edge && !data_s) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (sample_edge) begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (sample_edge) begin
                    par_d   = data_s;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (sample_edge) begin
                    state_d = StIdle;
                    if (data_s && parity_ok) begin
                        good_byte = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout loses to a sample edge arriving in the same cycle.
        if (state_q != StIdle && !sample_edge && to_cnt_q == ToW'(TIMEOUT - 1)) begin
            state_d   = StIdle;
            frame_err = 1'b1;
            to_cnt_d  = '0;
        end
    end

    // ---------------- byte decoder ----------------
    logic       ext_q, ext_d, brk_q, brk_d;
    logic [2:0] skip_q, skip_d;
    logic       strobe_q, strobe_d;
    logic       pressed_q, pressed_d;
    logic       extended_q, extended_d;
    logic [7:0] code_q, code_d;

    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        strobe_d   = strobe_q;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        code_d     = code_q;

        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (good_byte) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 1'b1;
            end else begin
                case (shift_q)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: brk_d = 1'b1;
                    8'hE1: begin
                        // Pause: swallow the remaining 7 bytes of the sequence.
                        skip_d = 3'd7;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end
                    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                    default: begin
                        code_d     = shift_q;
                        extended_d = ext_q;
                        pressed_d  = ~brk_q;
                        strobe_d   = ~strobe_q;
                        ext_d      = 1'b0;
                        brk_d      = 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- registers ----------------
    logic       byte_valid_q, frame_error_q;
    logic [7:0] byte_data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Lines idle high, so conditioning state resets high to avoid a false edge.
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            clk_filt_q    <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            to_cnt_q      <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            skip_q        <= '0;
            strobe_q      <= 1'b0;
            pressed_q     <= 1'b0;
            extended_q    <= 1'b0;
            code_q        <= '0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            frame_error_q <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[0], ps2_clk};
            data_sync_q   <= {data_sync_q[0], ps2_data};
            clk_filt_q    <= clk_filt_d;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            to_cnt_q      <= to_cnt_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            skip_q        <= skip_d;
            strobe_q      <= strobe_d;
            pressed_q     <= pressed_d;
            extended_q    <= extended_d;
            code_q        <= code_d;
            byte_valid_q  <= good_byte;
            frame_error_q <= frame_err;
            if (good_byte) begin
                byte_data_q <= shift_q;
            end
        end
    end

    assign key_if.key_strobe   = strobe_q;
    assign key_if.key_pressed  = pressed_q;
    assign key_if.key_extended = extended_q;
    assign key_if.key_code     = code_q;
    assign key_if.byte_valid   = byte_valid_q;
    assign key_if.byte_data    = byte_data_q;
    assign key_if.frame_error  = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed self-checking bench for ps2_key_decoder.
// Expected key events are queued when frames are sent and compared when key_strobe toggles.
module tb_ps2_key_decoder;

    localparam int unsigned FilterLen = 8;
    localparam int unsigned Timeout   = 400;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;

    ps2_key_decoder_if key_if ();

    ps2_key_decoder #(
        .FILTER_LEN (FilterLen),
        .TIMEOUT    (Timeout)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_if   (key_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       pressed;
        logic       ext;
    } ev_t;

    ev_t exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_ev    = 0;
    int n_bv    = 0;
    int n_fe    = 0;
    int last_fall_cyc = 0;
    int bv_cyc = 0;
    int fe_cyc = 0;
    int last_toggle_cyc = -10;
    logic prev_strobe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Monitor: pops the scoreboard on every key_strobe toggle and counts pulses.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_strobe = key_if.key_strobe;
        end else begin
            if (key_if.key_strobe !== prev_strobe) begin
                ev_t e;
                n_ev++;
                chk("strobe_spacing", 32'(cyc - last_toggle_cyc > 1), 1);
                last_toggle_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {24'h0, key_if.key_code}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("key_code", {24'h0, key_if.key_code}, {24'h0, e.code});
                    chk("key_pressed", {31'h0, key_if.key_pressed}, {31'h0, e.pressed});
                    chk("key_extended", {31'h0, key_if.key_extended}, {31'h0, e.ext});
                end
            end
            prev_strobe = key_if.key_strobe;
            if (key_if.byte_valid === 1'b1) begin
                n_bv++;
                bv_cyc = cyc;
            end
            if (key_if.frame_error === 1'b1) begin
                n_fe++;
                fe_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first n bits of an 11-bit frame (bit 0 = start) on the raw lines.
    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            idle(20);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            idle(40);
            ps2_clk = 1'b1;
            idle(20);
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit flip);
        logic par;
        par = ~(^b) ^ flip;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
    endtask

    task automatic push(input logic [7:0] code, input logic pressed, input logic ext);
        ev_t e;
        e.code = code;
        e.pressed = pressed;
        e.ext = ext;
        exp_q.push_back(e);
    endtask

    initial begin
        int ev0, bv0, fe0, d, waited;
        logic [7:0] pause_seq [10];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA, 8'h1C};

        // Reset state
        idle(5);
        chk("rst_key_strobe", {31'h0, key_if.key_strobe}, 0);
        chk("rst_key_pressed", {31'h0, key_if.key_pressed}, 0);
        chk("rst_key_extended", {31'h0, key_if.key_extended}, 0);
        chk("rst_key_code", {24'h0, key_if.key_code}, 0);
        chk("rst_byte_valid", {31'h0, key_if.byte_valid}, 0);
        chk("rst_byte_data", {24'h0, key_if.byte_data}, 0);
        chk("rst_frame_error", {31'h0, key_if.frame_error}, 0);
        reset_n = 1'b1;
        idle(20);

        // Plain make 1C
        ev0 = n_ev; bv0 = n_bv; fe0 = n_fe;
        push(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        idle(30);
        chk("make_events", n_ev - ev0, 1);
        chk("make_byte_valid", n_bv - bv0, 1);
        chk("make_byte_data", {24'h0, key_if.byte_data}, 32'h1C);
        chk("make_no_error", n_fe - fe0, 0);
        chk("make_drained", exp_q.size(), 0);
        d = bv_cyc - last_fall_cyc;
        chk("byte_valid_latency", 32'(d >= int'(FilterLen) + 1 && d <= int'(FilterLen) + 4), 1);

        // Extended break E0 F0 75
        ev0 = n_ev; bv0 = n_bv;
        push(8'h75, 1'b0, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        idle(30);
        chk("extbrk_events", n_ev - ev0, 1);
        chk("extbrk_byte_valid", n_bv - bv0, 3);
        chk("extbrk_drained", exp_q.size(), 0);

        // Parity error on 1C
        ev0 = n_ev; bv0 = n_bv; fe0 = n_fe;
`ifdef PS2_PARITY_CHECK_EN
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        idle(30);
        chk("parity_events", n_ev - ev0, 0);
        chk("parity_frame_error", n_fe - fe0, 1);
        chk("parity_byte_valid", n_bv - bv0, 0);
`else
        push(8'h1C, 1'b1, 1'b0);
        send_bits(mk_frame(8'h1C, 1'b1), 11);
        idle(30);
        chk("parity_events", n_ev - ev0, 1);
        chk("parity_frame_error", n_fe - fe0, 0);
        chk("parity_byte_valid", n_bv - bv0, 1);
`endif
        chk("parity_drained", exp_q.size(), 0);

        // Timeout after 4 data bits, then a full 29 frame
        ev0 = n_ev; fe0 = n_fe;
        send_bits(mk_frame(8'h29, 1'b0), 5);
        waited = 0;
        while (n_fe == fe0 && waited < 3 * int'(Timeout)) begin
            idle(1);
            waited++;
        end
        chk("timeout_fired", n_fe - fe0, 1);
        d = fe_cyc - last_fall_cyc;
        chk("timeout_latency", 32'(d >= int'(Timeout) && d <= int'(Timeout) + 16), 1);
        chk("timeout_no_event", n_ev - ev0, 0);
        push(8'h29, 1'b1, 1'b0);
        send_byte(8'h29);
        idle(30);
        chk("after_timeout_events", n_ev - ev0, 1);
        chk("after_timeout_drained", exp_q.size(), 0);

        // Pause sequence, response byte, then 1C
        ev0 = n_ev; bv0 = n_bv;
        push(8'h1C, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(pause_seq[i]);
        idle(30);
        chk("pause_events", n_ev - ev0, 1);
        chk("pause_byte_valid", n_bv - bv0, 10);
        chk("pause_drained", exp_q.size(), 0);

        // Glitch: 3-cycle low pulse on ps2_clk between frames
        ev0 = n_ev; bv0 = n_bv; fe0 = n_fe;
        ps2_clk = 1'b0;
        idle(3);
        ps2_clk = 1'b1;
        idle(Timeout + 50);
        chk("glitch_events", n_ev - ev0, 0);
        chk("glitch_byte_valid", n_bv - bv0, 0);
        chk("glitch_frame_error", n_fe - fe0, 0);

        // Reset after 5 bits, then a full 1C frame
        send_bits(mk_frame(8'h5A, 1'b0), 5);
        reset_n = 1'b0;
        idle(3);
        chk("midrst_key_code", {24'h0, key_if.key_code}, 0);
        chk("midrst_key_strobe", {31'h0, key_if.key_strobe}, 0);
        reset_n = 1'b1;
        ev0 = n_ev; fe0 = n_fe;
        idle(10);
        push(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        idle(Timeout + 50);
        chk("midrst_no_error", n_fe - fe0, 0);
        chk("midrst_events", n_ev - ev0, 1);
        chk("midrst_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
